uio_bus_arbiter: RTL

//  Shares the 8-bit bidirectional uio pad bus of tt_um_main_anonymousseal among
//  N internal requesters using round-robin arbitration with bounded tenure.

---
 rtl/uio_bus_arbiter_pkg.sv | 24 ++
 rtl/uio_bus_arbiter_rr_picker.sv | 24 ++
 rtl/uio_bus_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Also provides the width helper used to size its counters.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_HIZ   = 8'h00;

    // Bits needed to count 0..value-1, never less than one so degenerate parameters still elaborate.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester found scanning ptr, ptr+1, ... mod N.
// Its outputs are a one-hot winner and a flag that anyone was requesting.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                winner[(int'(ptr) + k) % N] = 1'b1;
                valid                       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pad bus: grants tenures to N requesters, registers the
// pad drive/capture, and inserts a tri-stated turnaround between tenures.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BEATS = 16,
    parameter int TURN_CYC  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   we,
    input  logic [N-1:0]   last,
    input  logic [8*N-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic           beat,
    output logic [7:0]     rdata,
    output logic           rvalid,
    input  logic [7:0]     uio_in,
    output logic [7:0]     uio_out,
    output logic [7:0]     uio_oe
);

    localparam int PW = clog2(N);
    localparam int CW = clog2(MAX_BEATS);
    localparam int TW = clog2(TURN_CYC);

    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BEATS - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N - 1);

    arb_state_t    state, state_next;
    logic [N-1:0]  gnt_next;
    logic [PW-1:0] owner, owner_next;
    logic          dir, dir_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [TW-1:0] turn_cnt, turn_cnt_next;
    logic [PW-1:0] rr_ptr, rr_ptr_next;
    logic [7:0]    uio_out_next;
    logic [7:0]    uio_oe_next;
    logic [7:0]    rdata_next;
    logic          rvalid_next;

    logic [N-1:0]  pick_onehot;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic          pick_we;
    logic          req_sel;
    logic          last_sel;
    logic [7:0]    wbyte;
    logic          tenure_end;

    rr_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    // Route the current owner's and the prospective winner's signals out of the packed buses.
    always_comb begin
        req_sel  = 1'b0;
        last_sel = 1'b0;
        wbyte    = '0;
        pick_idx = '0;
        pick_we  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (owner == PW'(i)) begin
                req_sel  = req[i];
                last_sel = last[i];
                wbyte    = wdata[8*i +: 8];
            end
            if (pick_onehot[i]) begin
                pick_idx = PW'(i);
                pick_we  = we[i];
            end
        end
    end

    assign beat       = (state == XFER) && req_sel;
    assign tenure_end = !req_sel || (beat && (last_sel || (cnt == CNT_LAST)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            dir      <= 1'b0;
            cnt      <= '0;
            turn_cnt <= '0;
            rr_ptr   <= '0;
            uio_out  <= '0;
            uio_oe   <= OE_HIZ;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            state    <= state_next;
            gnt      <= gnt_next;
            owner    <= owner_next;
            dir      <= dir_next;
            cnt      <= cnt_next;
            turn_cnt <= turn_cnt_next;
            rr_ptr   <= rr_ptr_next;
            uio_out  <= uio_out_next;
            uio_oe   <= uio_oe_next;
            rdata    <= rdata_next;
            rvalid   <= rvalid_next;
        end
    end

    // Pads fall back to hi-Z on any cycle that is not a write beat, so TURN always tri-states.
    always_comb begin
        state_next    = state;
        gnt_next      = gnt;
        owner_next    = owner;
        dir_next      = dir;
        cnt_next      = cnt;
        turn_cnt_next = turn_cnt;
        rr_ptr_next   = rr_ptr;
        uio_out_next  = uio_out;
        uio_oe_next   = OE_HIZ;
        rdata_next    = rdata;
        rvalid_next   = 1'b0;

        case (state)
            IDLE: begin
                if (ena && pick_valid) begin
                    state_next = XFER;
                    gnt_next   = pick_onehot;
                    owner_next = pick_idx;
                    dir_next   = pick_we;
                    cnt_next   = '0;
                end
            end

            XFER: begin
                if (beat) begin
                    cnt_next = cnt + CW'(1);
                    if (dir) begin
                        uio_out_next = wbyte;
                        uio_oe_next  = OE_DRIVE;
                    end else begin
                        rdata_next  = uio_in;
                        rvalid_next = 1'b1;
                    end
                end
                if (tenure_end) begin
                    state_next    = TURN;
                    gnt_next      = '0;
                    turn_cnt_next = '0;
                    rr_ptr_next   = (owner == PTR_LAST) ? '0 : owner + PW'(1);
                end
            end

            TURN: begin
                gnt_next = '0;
                if (turn_cnt == TURN_LAST) begin
                    state_next = IDLE;
                end else begin
                    turn_cnt_next = turn_cnt + TW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

endmodule
